calc_operand_regs: RTL and testbench

CALC_OPERAND_REGS -- requirements
Module: calc_operand_regs

---
 rtl/calc_operand_regs.sv | 98 +++++++++
 tb/tb_calc_operand_regs.sv | 134 +++++++++++++
 2 files changed

// File: rtl/calc_operand_regs.sv
// Operand entry registers for a hex keypad calculator: digit entry, backspace,
// operator latch and result capture, with the displayed operand registered on v1.
module calc_operand_regs #(
    parameter int DIGITS = 4,
    parameter int OPW    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  newhex,
    input  logic [3:0]            hexcode,
    input  logic                  newop,
    input  logic [OPW-1:0]        opcode,
    input  logic                  eq,
    input  logic                  bksp,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   ans,
    output logic [4*DIGITS-1:0]   v1,
    output logic [4*DIGITS-1:0]   v2,
    output logic [OPW-1:0]        op_reg,
    output logic                  mode,
    output logic                  full
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    typedef enum logic {
        ENTRY  = 1'b0,
        RESULT = 1'b1
    } mode_t;

    mode_t          state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [W-1:0]   v1_next, v2_next;
    logic [OPW-1:0] op_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ENTRY;
            cnt    <= '0;
            v1     <= '0;
            v2     <= '0;
            op_reg <= '0;
            full   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            v1     <= v1_next;
            v2     <= v2_next;
            op_reg <= op_next;
            full   <= (cnt_next == CNT_MAX);
        end
    end

    // Only the highest-priority pulse acts; lower ones are dropped even when
    // the winning event turns out to be a no-op (e.g. bksp in RESULT).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        v1_next    = v1;
        v2_next    = v2;
        op_next    = op_reg;
        if (clr) begin
            state_next = ENTRY;
            cnt_next   = '0;
            v1_next    = '0;
            v2_next    = '0;
            op_next    = '0;
        end else if (eq) begin
            state_next = RESULT;
            cnt_next   = '0;
            v1_next    = ans;
        end else if (newop) begin
            state_next = RESULT;
            cnt_next   = '0;
            v2_next    = v1;
            op_next    = opcode;
        end else if (bksp) begin
            if (state == ENTRY && cnt != '0) begin
                v1_next  = v1 >> 4;
                cnt_next = cnt - 1'b1;
            end
        end else if (newhex) begin
            if (state == RESULT) begin
                state_next = ENTRY;
                cnt_next   = CW'(1);
                v1_next    = W'(hexcode);
            end else if (cnt != CNT_MAX) begin
                v1_next  = (v1 << 4) | W'(hexcode);
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_calc_operand_regs.sv
// Directed and randomized bench for calc_operand_regs against a value-level model.
module tb_calc_operand_regs;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        newhex = 1'b0;
    logic [3:0]  hexcode = '0;
    logic        newop = 1'b0;
    logic [1:0]  opcode = '0;
    logic        eq = 1'b0;
    logic        bksp = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] ans = '0;
    logic [15:0] v1, v2;
    logic [1:0]  op_reg;
    logic        mode, full;

    int total = 0;
    int passed = 0;

    // Reference state as plain integers: operand values and digit count.
    int m_v1 = 0, m_v2 = 0, m_op = 0, m_mode = 0, m_cnt = 0;

    calc_operand_regs #(.DIGITS(4), .OPW(2)) dut (
        .clock(clock), .reset(reset), .newhex(newhex), .hexcode(hexcode),
        .newop(newop), .opcode(opcode), .eq(eq), .bksp(bksp), .clr(clr),
        .ans(ans), .v1(v1), .v2(v2), .op_reg(op_reg), .mode(mode), .full(full)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".v1"},     32'(v1),      32'(m_v1));
        check({tag, ".v2"},     32'(v2),      32'(m_v2));
        check({tag, ".op_reg"}, 32'(op_reg),  32'(m_op));
        check({tag, ".mode"},   32'(mode),    32'(m_mode));
        check({tag, ".full"},   32'(full),    32'(m_cnt == 4));
        check({tag, ".cnt"},    32'(dut.cnt), 32'(m_cnt));
    endtask

    task automatic model(input logic r, c, e, no, b, nh,
                         input logic [3:0] hc, input logic [1:0] oc, input logic [15:0] a);
        if (r || c) begin
            m_v1 = 0; m_v2 = 0; m_op = 0; m_mode = 0; m_cnt = 0;
        end else if (e) begin
            m_v1 = a; m_cnt = 0; m_mode = 1;
        end else if (no) begin
            m_v2 = m_v1; m_op = oc; m_cnt = 0; m_mode = 1;
        end else if (b) begin
            if (m_mode == 0 && m_cnt > 0) begin
                m_v1 = m_v1 / 16; m_cnt--;
            end
        end else if (nh) begin
            if (m_mode == 1) begin
                m_v1 = hc; m_cnt = 1; m_mode = 0;
            end else if (m_cnt < 4) begin
                m_v1 = (m_v1 * 16 + hc) % 65536; m_cnt++;
            end
        end
    endtask

    task automatic drive(input string tag, input logic r, c, e, no, b, nh,
                         input logic [3:0] hc, input logic [1:0] oc, input logic [15:0] a);
        reset = r; clr = c; eq = e; newop = no; bksp = b; newhex = nh;
        hexcode = hc; opcode = oc; ans = a;
        @(posedge clock);
        #1;
        model(r, c, e, no, b, nh, hc, oc, a);
        reset = 0; clr = 0; eq = 0; newop = 0; bksp = 0; newhex = 0;
        check_all(tag);
    endtask

    task automatic hex(input string tag, input logic [3:0] d);
        drive(tag, 0, 0, 0, 0, 0, 1, d, 2'd0, 16'h0);
    endtask

    initial begin
        #2;
        drive("reset", 1, 0, 0, 0, 0, 0, 4'h0, 2'd0, 16'h0);
        check("reset.v1_zero", 32'(v1), 32'h0);

        hex("h1", 4'h1); hex("h2", 4'h2); hex("h3", 4'h3); hex("h4", 4'h4);
        check("entry_1234", 32'(v1), 32'h1234);
        check("entry_full", 32'(full), 32'h1);
        hex("h5_ignored", 4'h5);
        check("full_hold", 32'(v1), 32'h1234);

        drive("newop", 0, 0, 0, 1, 0, 0, 4'h0, 2'd2, 16'h0);
        check("newop_v2", 32'(v2), 32'h1234);
        hex("h7_result", 4'h7);
        check("restart_v1", 32'(v1), 32'h0007);
        drive("eq", 0, 0, 1, 0, 0, 0, 4'h0, 2'd0, 16'h123B);
        check("eq_v1", 32'(v1), 32'h123B);
        drive("bksp_result", 0, 0, 0, 0, 1, 0, 4'h0, 2'd0, 16'h0);

        drive("clr", 0, 1, 0, 0, 0, 0, 4'h0, 2'd0, 16'h0);
        hex("e1", 4'h1); hex("e2", 4'h2); hex("e3", 4'h3);
        drive("bk1", 0, 0, 0, 0, 1, 0, 4'h0, 2'd0, 16'h0);
        check("bk1_v1", 32'(v1), 32'h0012);
        drive("bk2", 0, 0, 0, 0, 1, 0, 4'h0, 2'd0, 16'h0);
        drive("bk3", 0, 0, 0, 0, 1, 0, 4'h0, 2'd0, 16'h0);
        drive("bk4_empty", 0, 0, 0, 0, 1, 0, 4'h0, 2'd0, 16'h0);

        hex("p1", 4'h9);
        drive("eq_newop_hex", 0, 0, 1, 1, 0, 1, 4'h5, 2'd3, 16'hBEEF);
        check("prio_eq_v1", 32'(v1), 32'hBEEF);
        drive("clr_eq", 0, 1, 1, 0, 0, 0, 4'h0, 2'd1, 16'hCAFE);

        hex("m1", 4'hA); hex("m2", 4'hB);
        drive("reset_mid", 1, 0, 0, 0, 0, 1, 4'hC, 2'd0, 16'h0);
        check("reset_mid_v1", 32'(v1), 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic r, c, e, no, b, nh;
            r  = ($urandom_range(0, 59) == 0);
            c  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 7) == 0);
            no = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 4) == 0);
            nh = ($urandom_range(0, 1) == 0);
            drive("rand", r, c, e, no, b, nh, 4'($urandom), 2'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
